// File: rtl/led_pwm_pkg.sv
// Shared types and default constants for the LED PWM bank.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_PWM     = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_e;

    localparam int N_CH_DEF       = 8;
    localparam int CNT_W_DEF      = 16;
    localparam int PRE_W_DEF      = 8;
    localparam int PERIOD_DEF_VAL = 10000;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: staged/shadow config, breathe level tracking and the
// registered output comparator.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLOCK50,
    input  logic             RESET_N,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_duty,
    input  logic [1:0]       wr_mode,
    input  logic             wrap_p0,
    input  logic [CNT_W-1:0] cnt_p0,
    output logic             led_p1
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] duty_st;
    logic [CNT_W-1:0] duty_sh;
    led_mode_e        mode_st;
    led_mode_e        mode_sh;
    logic [CNT_W-1:0] level;
    logic [CNT_W-1:0] level_nxt;
    logic             dir_down;
    logic             dir_down_nxt;
    logic             led_nxt;

    // Breathe step evaluated against the config about to become active at wrap.
    always_comb begin
        level_nxt    = level;
        dir_down_nxt = dir_down;
        if (mode_st != MODE_BREATHE || mode_sh != MODE_BREATHE) begin
            level_nxt    = '0;
            dir_down_nxt = 1'b0;
        end else if (duty_st == '0) begin
            level_nxt    = '0;
            dir_down_nxt = 1'b0;
        end else if (duty_st < level) begin
            level_nxt    = duty_st;
            dir_down_nxt = 1'b1;
        end else if (!dir_down) begin
            if (level == duty_st) begin
                level_nxt    = level - ONE;
                dir_down_nxt = 1'b1;
            end else begin
                level_nxt = level + ONE;
            end
        end else begin
            if (level == '0) begin
                level_nxt    = level + ONE;
                dir_down_nxt = 1'b0;
            end else begin
                level_nxt = level - ONE;
            end
        end
    end

    always_comb begin
        led_nxt = 1'b0;
        case (mode_sh)
            MODE_ON:      led_nxt = 1'b1;
            MODE_PWM:     led_nxt = (cnt_p0 < duty_sh);
            MODE_BREATHE: led_nxt = (cnt_p0 < level);
            default:      led_nxt = 1'b0;
        endcase
    end

    // p0 -> p1: config capture, shadow load on wrap, registered LED drive
    always_ff @(posedge CLOCK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            duty_st  <= '0;
            mode_st  <= MODE_OFF;
            duty_sh  <= '0;
            mode_sh  <= MODE_OFF;
            level    <= '0;
            dir_down <= 1'b0;
            led_p1   <= 1'b0;
        end else begin
            if (wr_en) begin
                duty_st <= wr_duty;
                mode_st <= led_mode_e'(wr_mode);
            end
            if (wrap_p0) begin
                duty_sh  <= duty_st;
                mode_sh  <= mode_st;
                level    <= level_nxt;
                dir_down <= dir_down_nxt;
            end
            led_p1 <= led_nxt;
        end
    end

endmodule

// File: rtl/led_pwm_bank.sv
// Bank of LED PWM channels sharing one prescaler and one period counter;
// channel config and the period become active only at a period wrap.
module led_pwm_bank
    import led_pwm_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int PRE_W      = PRE_W_DEF,
    parameter int PERIOD_DEF = PERIOD_DEF_VAL,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             CLOCK50,
    input  logic             RESET_N,
    input  logic [PRE_W-1:0] prescale_in,
    input  logic [CNT_W-1:0] period_in,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic [1:0]       cfg_mode,
    output logic [N_CH-1:0]  led_out,
    output logic             period_tick
);

    localparam logic [31:0] N_CH_U = N_CH;

    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] cnt_p0;
    logic [CNT_W-1:0] period_sh;
    logic             ce_p0;
    logic             wrap_p0;
    logic [31:0]      ch_idx;
    logic             wr_ok;

    // >= keeps the prescaler from running away if prescale_in drops below it
    assign ce_p0   = (pre_cnt >= prescale_in);
    assign wrap_p0 = ce_p0 && (cnt_p0 == period_sh);
    assign ch_idx  = 32'(cfg_ch);
    assign wr_ok   = cfg_we && (ch_idx < N_CH_U);

    // p0: shared timebase
    always_ff @(posedge CLOCK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_cnt     <= '0;
            cnt_p0      <= '0;
            period_sh   <= CNT_W'(PERIOD_DEF);
            period_tick <= 1'b0;
        end else begin
            pre_cnt <= ce_p0 ? '0 : pre_cnt + 1'b1;
            if (ce_p0) begin
                cnt_p0 <= wrap_p0 ? '0 : cnt_p0 + 1'b1;
            end
            if (wrap_p0) begin
                period_sh <= period_in;
            end
            period_tick <= wrap_p0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [31:0] IDX = i;

        led_pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .CLOCK50 (CLOCK50),
            .RESET_N (RESET_N),
            .wr_en   (wr_ok && (ch_idx == IDX)),
            .wr_duty (cfg_duty),
            .wr_mode (cfg_mode),
            .wrap_p0 (wrap_p0),
            .cnt_p0  (cnt_p0),
            .led_p1  (led_out[i])
        );
    end

endmodule

// File: doc/led_pwm_bank.md
LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 Parameter N_CH, default 8, number of LED channels (1..32).
REQ-002 Parameter CNT_W, default 16, width of period counter and duty values.
REQ-003 Parameter PRE_W, default 8, width of prescaler.
REQ-004 Parameter PERIOD_DEF, default 10000, period value loaded at reset.
REQ-005 CLOCK50  in  1  sole clock; all flops on rising edge.
REQ-006 RESET_N  in  1  asynchronous, active-low reset.
REQ-007 prescale_in  in  PRE_W  clock-enable divide value; sampled every cycle.
REQ-008 period_in  in  CNT_W  requested period (terminal count); sampled at wrap only.
REQ-009 cfg_we  in  1  one-cycle write strobe for channel config.
REQ-010 cfg_ch  in  clog2(N_CH)  channel index for the write.
REQ-011 cfg_duty  in  CNT_W  duty value for the write.
REQ-012 cfg_mode  in  2  mode for the write: 0 OFF, 1 ON, 2 PWM, 3 BREATHE.
REQ-013 led_out  out  N_CH  registered LED drive, one bit per channel.
REQ-014 period_tick  out  1  one-cycle pulse at each period wrap.

Function
REQ-015 Prescaler counts 0..prescale_in; ce asserted in the cycle it equals prescale_in, then returns to 0; prescale_in=0 gives ce every cycle.
REQ-016 Period counter advances only on ce, counts 0..period_sh, wraps to 0; period_sh=0 holds counter at 0 with a wrap on every ce.
REQ-017 Wrap = ce AND counter==period_sh; period_tick is asserted in the cycle after wrap (registered), exactly one cycle wide.
REQ-018 cfg_we writes cfg_duty/cfg_mode into channel cfg_ch staged registers; cfg_ch >= N_CH is ignored.
REQ-019 On wrap: period_sh <= period_in; each channel duty_sh/mode_sh <= staged values; mid-period writes never alter the current period.
REQ-020 Write and wrap in the same cycle: shadow takes the pre-write staged value; new value applies at the following wrap.
REQ-021 OFF: led=0. ON: led=1. PWM: led = (counter < duty_sh), unsigned compare.
REQ-022 PWM boundaries: duty_sh=0 -> constant 0; duty_sh > period_sh -> constant 1.
REQ-023 BREATHE: led = (counter < level); level steps by 1 at each wrap, upward until level==duty_sh, then downward until 0, then upward; direction flips on the wrap at the end value.
REQ-024 BREATHE with duty_sh=0 holds level at 0; if duty_sh drops below current level at a wrap, level is loaded with duty_sh and direction set down.
REQ-025 Leaving BREATHE at a wrap resets level to 0, direction up.
REQ-026 led_out is registered: one cycle latency from counter/shadow state; no combinational input-to-output path.

Reset
REQ-027 RESET_N low asynchronously clears: prescaler, counter, led_out, period_tick to 0; period_sh to PERIOD_DEF; all staged and shadow duty to 0 and mode to OFF; all levels 0, direction up.
REQ-028 Reset mid-period aborts the period; after release, counting restarts from 0 and first wrap occurs after PERIOD_DEF+1 ce pulses.
REQ-029 Reset deassertion is synchronised externally; block requires no internal synchroniser.

Structure
REQ-030 Package led_pwm_pkg holds the mode enum (OFF/ON/PWM/BREATHE) and default constants.
REQ-031 Shared prescaler and period counter live in led_pwm_bank; per-channel staged/shadow registers, comparator and breathe logic live in sub-module led_pwm_channel, instantiated N_CH times by generate.

Verification
REQ-032 prescale_in=0, period_in=9, ch0 PWM duty 3 -> led_out[0] high 3 of every 10 cycles, period_tick every 10 cycles.
REQ-033 prescale_in=1, period_in=4, ch1 PWM duty 5 -> led_out[1] constant 1; duty 0 -> constant 0 after next wrap.
REQ-034 Change ch2 duty 2->7 mid-period (period 9) -> current period keeps 2 high cycles, next period shows 7.
REQ-035 ch3 BREATHE duty 3, period 9 -> high-time per period 0,1,2,3,2,1,0,1.
REQ-036 Assert RESET_N low mid-period with all channels ON -> led_out=0 and period_tick=0 immediately, no clock edge required; first tick after release at PERIOD_DEF+1 ce.
REQ-037 cfg_we coincident with wrap on ch4 (OFF->ON) -> ch4 stays OFF one more period, then ON.
